// File: rtl/hpi_target.sv
// hpi_target: HPI target with the DATA/MAILBOX/ADDRESS/STATUS register map.
// It has an internal word RAM and a bidirectional mailbox to a device-side agent.
// It runs in the initiator's clock domain, so no synchronizers are needed.
module hpi_target #(
   parameter int DEPTH_W = 10
) (
   input  logic        Clk,
   input  logic        Reset_n,
   inout  wire  [15:0] OTG_DATA,
   input  logic [1:0]  OTG_ADDR,
   input  logic        OTG_CS_N,
   input  logic        OTG_RD_N,
   input  logic        OTG_WR_N,
   input  logic        OTG_RST_N,
   output logic        OTG_INT,
   input  logic [15:0] dev_mbx_wdata,
   input  logic        dev_mbx_we,
   output logic        dev_mbx_wready,
   output logic [15:0] dev_mbx_rdata,
   output logic        dev_mbx_rvalid,
   input  logic        dev_mbx_ack
);

   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_MBX  = 2'd1;
   localparam logic [1:0] REG_ADDR = 2'd2;
   localparam logic [1:0] REG_STAT = 2'd3;
   localparam int RAM_WORDS = 1 << DEPTH_W;

   logic [15:0] mem [RAM_WORDS];

   logic [15:0]        addr_reg_q, addr_reg_d;
   logic [15:0]        mbx_in_q, mbx_in_d;
   logic [15:0]        mbx_out_q, mbx_out_d;
   logic               mbx_in_flag_q, mbx_in_flag_d;
   logic               mbx_out_flag_q, mbx_out_flag_d;
   logic               ovr_q, ovr_d;
   logic [15:0]        rdata_q, rdata_d;
   logic               oe_q, oe_d;
   logic               prev_rd_q, prev_rd_d;
   logic               prev_wr_q, prev_wr_d;
   logic               ram_we_q, ram_we_d;
   logic [DEPTH_W-1:0] ram_waddr_q, ram_waddr_d;
   logic [15:0]        ram_wdata_q, ram_wdata_d;

   logic               rd_now, wr_now, rd_start, wr_start;
   logic [DEPTH_W-1:0] ram_idx;
   logic [15:0]        ram_rword;
   logic [15:0]        status_word;

   // Decode strobes into single-cycle access starts; RD+WR together is neither.
   always_comb begin
      rd_now      = ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N;
      wr_now      = ~OTG_CS_N & ~OTG_WR_N & OTG_RD_N;
      rd_start    = rd_now & ~prev_rd_q & OTG_RST_N;
      wr_start    = wr_now & ~prev_wr_q & OTG_RST_N;
      ram_idx     = addr_reg_q[DEPTH_W:1];
      // RAM writes commit one cycle late, so forward the pending word to a read.
      // This lets a read that starts right after a write see the new value.
      ram_rword   = (ram_we_q && (ram_waddr_q == ram_idx)) ? ram_wdata_q : mem[ram_idx];
      status_word = {7'b0, mbx_in_flag_q, 6'b0, ovr_q, mbx_out_flag_q};
   end

   // Next-state logic for registers, flags, read data and bus enable.
   always_comb begin
      addr_reg_d     = addr_reg_q;
      mbx_in_d       = mbx_in_q;
      mbx_out_d      = mbx_out_q;
      mbx_in_flag_d  = mbx_in_flag_q;
      mbx_out_flag_d = mbx_out_flag_q;
      ovr_d          = ovr_q;
      rdata_d        = rdata_q;
      prev_rd_d      = rd_now;
      prev_wr_d      = wr_now;
      ram_we_d       = 1'b0;
      ram_waddr_d    = ram_waddr_q;
      ram_wdata_d    = ram_wdata_q;
      // Drive only while the read that this target started is still held.
      oe_d           = rd_now & OTG_RST_N & (rd_start | oe_q);
      if (!OTG_RST_N) begin
         addr_reg_d     = 16'h0000;
         mbx_in_d       = 16'h0000;
         mbx_out_d      = 16'h0000;
         mbx_in_flag_d  = 1'b0;
         mbx_out_flag_d = 1'b0;
         ovr_d          = 1'b0;
      end else begin
         if (dev_mbx_ack) mbx_in_flag_d = 1'b0;
         if (wr_start) begin
            case (OTG_ADDR)
               REG_DATA: begin
                  ram_we_d    = 1'b1;
                  ram_waddr_d = ram_idx;
                  ram_wdata_d = OTG_DATA;
                  addr_reg_d  = addr_reg_q + 16'd2;
               end
               REG_MBX: begin
                  // A host write wins over a same-cycle device ack.
                  mbx_in_d      = OTG_DATA;
                  mbx_in_flag_d = 1'b1;
                  if (mbx_in_flag_q) ovr_d = 1'b1;
               end
               REG_ADDR: addr_reg_d = {OTG_DATA[15:1], 1'b0};
               default:  ;
            endcase
         end
         if (rd_start) begin
            case (OTG_ADDR)
               REG_DATA: begin
                  rdata_d    = ram_rword;
                  addr_reg_d = addr_reg_q + 16'd2;
               end
               REG_MBX: begin
                  rdata_d        = mbx_out_q;
                  mbx_out_flag_d = 1'b0;
               end
               REG_ADDR: rdata_d = addr_reg_q;
               default: begin
                  rdata_d = status_word;
                  ovr_d   = 1'b0;
               end
            endcase
         end
         // The device may only load the outbound word when the previous one is gone.
         if (dev_mbx_we && !mbx_out_flag_q) begin
            mbx_out_d      = dev_mbx_wdata;
            mbx_out_flag_d = 1'b1;
         end
      end
   end

   // State registers; Reset_n aborts any access in progress, including a pending RAM write.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         addr_reg_q     <= 16'h0000;
         mbx_in_q       <= 16'h0000;
         mbx_out_q      <= 16'h0000;
         mbx_in_flag_q  <= 1'b0;
         mbx_out_flag_q <= 1'b0;
         ovr_q          <= 1'b0;
         rdata_q        <= 16'h0000;
         oe_q           <= 1'b0;
         prev_rd_q      <= 1'b0;
         prev_wr_q      <= 1'b0;
         ram_we_q       <= 1'b0;
         ram_waddr_q    <= '0;
         ram_wdata_q    <= 16'h0000;
      end else begin
         addr_reg_q     <= addr_reg_d;
         mbx_in_q       <= mbx_in_d;
         mbx_out_q      <= mbx_out_d;
         mbx_in_flag_q  <= mbx_in_flag_d;
         mbx_out_flag_q <= mbx_out_flag_d;
         ovr_q          <= ovr_d;
         rdata_q        <= rdata_d;
         oe_q           <= oe_d;
         prev_rd_q      <= prev_rd_d;
         prev_wr_q      <= prev_wr_d;
         ram_we_q       <= ram_we_d;
         ram_waddr_q    <= ram_waddr_d;
         ram_wdata_q    <= ram_wdata_d;
      end
   end

   // Word RAM; contents are not reset and survive a host soft reset.
   always_ff @(posedge Clk) begin
      if (ram_we_q) mem[ram_waddr_q] <= ram_wdata_q;
   end

   assign OTG_DATA       = oe_q ? rdata_q : 16'hzzzz;
   assign OTG_INT        = mbx_out_flag_q;
   assign dev_mbx_wready = ~mbx_out_flag_q;
   assign dev_mbx_rdata  = mbx_in_q;
   assign dev_mbx_rvalid = mbx_in_flag_q;

endmodule

// File: tb/tb_hpi_target.sv
// Testbench for hpi_target: directed HPI bus and device-side mailbox vectors.
// A scoreboard queue carries the expected values to a negedge monitor.
module tb_hpi_target;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  localparam int SEL_BUS    = 0;
  localparam int SEL_INT    = 1;
  localparam int SEL_WREADY = 2;
  localparam int SEL_RVALID = 3;
  localparam int SEL_RDATA  = 4;

  logic        clk;
  logic        reset_n;
  wire  [15:0] otg_data;
  logic        tb_drv;
  logic [15:0] tb_wdata;
  logic [1:0]  otg_addr;
  logic        cs_n, rd_n, wr_n, otg_rst_n;
  logic        otg_int;
  logic [15:0] dev_wdata;
  logic        dev_we;
  logic        dev_wready;
  logic [15:0] dev_rdata;
  logic        dev_rvalid;
  logic        dev_ack;

  // The bus idles high, so a released bus reads 16'hFFFF.
  pullup (otg_data);
  assign otg_data = tb_drv ? tb_wdata : 16'hzzzz;

  hpi_target #(.DEPTH_W(10)) dut (
    .Clk            (clk),
    .Reset_n        (reset_n),
    .OTG_DATA       (otg_data),
    .OTG_ADDR       (otg_addr),
    .OTG_CS_N       (cs_n),
    .OTG_RD_N       (rd_n),
    .OTG_WR_N       (wr_n),
    .OTG_RST_N      (otg_rst_n),
    .OTG_INT        (otg_int),
    .dev_mbx_wdata  (dev_wdata),
    .dev_mbx_we     (dev_we),
    .dev_mbx_wready (dev_wready),
    .dev_mbx_rdata  (dev_rdata),
    .dev_mbx_rvalid (dev_rvalid),
    .dev_mbx_ack    (dev_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string n, input int s, input logic [15:0] e);
    chk_t c;
    c.name = n;
    c.sel  = s;
    c.exp  = e;
    sb.push_back(c);
  endtask

  task automatic check_now(input string n, input logic [15:0] act, input logic [15:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", n, act, e, $time);
    end
  endtask

  // Monitor: pops every pending expectation and compares it away from the active edge.
  chk_t        mc;
  logic [15:0] mact;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mc = sb.pop_front();
      case (mc.sel)
        SEL_BUS:    mact = otg_data;
        SEL_INT:    mact = {15'b0, otg_int};
        SEL_WREADY: mact = {15'b0, dev_wready};
        SEL_RVALID: mact = {15'b0, dev_rvalid};
        default:    mact = dev_rdata;
      endcase
      checks++;
      if (mact !== mc.exp) begin
        errors++;
        $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", mc.name, mact, mc.exp, $time);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_int(input logic v, input string n);
    int k;
    k = 0;
    while (otg_int !== v && k < 10) begin
      cyc();
      k++;
    end
    checks++;
    if (otg_int !== v) begin
      errors++;
      $display("FAIL %s: wait for OTG_INT=%0b expired at %0t", n, v, $time);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    cyc();
    otg_addr = a; tb_wdata = d; tb_drv = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    cyc();
    cs_n = 1'b1; wr_n = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [15:0] e, input string n);
    cyc();
    otg_addr = a; cs_n = 1'b0; rd_n = 1'b0;
    cyc();
    push(n, SEL_BUS, e);
    cyc();
    cs_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic dev_write(input logic [15:0] d);
    cyc();
    dev_wdata = d; dev_we = 1'b1;
    cyc();
    dev_we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; tb_drv = 1'b0; tb_wdata = 16'h0000; otg_addr = A_DATA;
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; otg_rst_n = 1'b1;
    dev_wdata = 16'h0000; dev_we = 1'b0; dev_ack = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;

    // Reset state
    check_now("rst_int", {15'b0, otg_int}, 16'h0000);
    check_now("rst_wready", {15'b0, dev_wready}, 16'h0001);
    check_now("rst_rvalid", {15'b0, dev_rvalid}, 16'h0000);
    check_now("rst_rdata", dev_rdata, 16'h0000);
    check_now("rst_idle_bus", otg_data, 16'hFFFF);
    bus_read(A_STAT, 16'h0000, "rst_status");

    // DATA burst
    bus_write(A_ADDR, 16'h0010);
    bus_write(A_DATA, 16'hA5A5);
    bus_write(A_DATA, 16'h1234);
    bus_write(A_DATA, 16'hBEEF);
    bus_write(A_ADDR, 16'h0010);
    bus_read(A_DATA, 16'hA5A5, "burst_rd0");
    bus_read(A_DATA, 16'h1234, "burst_rd1");
    bus_read(A_DATA, 16'hBEEF, "burst_rd2");
    bus_read(A_ADDR, 16'h0016, "burst_addr");
    cyc();
    push("idle_after_read", SEL_BUS, 16'hFFFF);

    // Wrap, odd address and aliasing
    bus_write(A_ADDR, 16'hFFFF);
    bus_read(A_ADDR, 16'hFFFE, "odd_addr");
    bus_write(A_DATA, 16'h7777);
    bus_read(A_ADDR, 16'h0000, "wrap_addr");
    bus_write(A_ADDR, 16'h0800);
    bus_write(A_DATA, 16'hC0DE);
    bus_write(A_ADDR, 16'h0000);
    bus_read(A_DATA, 16'hC0DE, "alias_rd");
    bus_write(A_ADDR, 16'h07FE);
    bus_read(A_DATA, 16'h7777, "top_word_rd");

    // Mailbox in
    bus_write(A_MBX, 16'h5555);
    push("mbx_in_rvalid", SEL_RVALID, 16'h0001);
    push("mbx_in_rdata", SEL_RDATA, 16'h5555);
    bus_write(A_MBX, 16'h6666);
    bus_read(A_STAT, 16'h0102, "status_ovr");
    bus_read(A_STAT, 16'h0100, "status_ovr_clr");
    push("mbx_in_rdata2", SEL_RDATA, 16'h6666);
    cyc(); dev_ack = 1'b1;
    cyc(); dev_ack = 1'b0;
    push("ack_rvalid", SEL_RVALID, 16'h0000);

    // Mailbox out
    dev_write(16'h0BAD);
    wait_int(1'b1, "mbx_out_int_wait");
    push("mbx_out_int", SEL_INT, 16'h0001);
    push("mbx_out_wready", SEL_WREADY, 16'h0000);
    dev_write(16'h0001);
    bus_read(A_STAT, 16'h0001, "status_out");
    bus_read(A_MBX, 16'h0BAD, "mbx_out_rd");
    push("mbx_out_int_clr", SEL_INT, 16'h0000);
    push("mbx_out_wready_set", SEL_WREADY, 16'h0001);
    wait_int(1'b0, "mbx_out_int_clr_wait");

    // RD_N held low five cycles: one increment only
    bus_write(A_ADDR, 16'h0020);
    bus_write(A_DATA, 16'h4321);
    bus_write(A_ADDR, 16'h0020);
    cyc();
    otg_addr = A_DATA; cs_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      push("long_rd_bus", SEL_BUS, 16'h4321);
    end
    cs_n = 1'b1; rd_n = 1'b1;
    cyc();
    push("long_rd_release", SEL_BUS, 16'hFFFF);
    bus_read(A_ADDR, 16'h0022, "long_rd_addr");

    // Illegal RD_N=WR_N=0
    cyc();
    otg_addr = A_DATA; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    cyc();
    push("illegal_bus", SEL_BUS, 16'hFFFF);
    cyc();
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    bus_read(A_ADDR, 16'h0022, "illegal_addr");

    // Host soft reset
    bus_write(A_ADDR, 16'h0030);
    bus_write(A_MBX, 16'h1111);
    dev_write(16'h2222);
    push("pre_srst_int", SEL_INT, 16'h0001);
    push("pre_srst_rvalid", SEL_RVALID, 16'h0001);
    cyc(); otg_rst_n = 1'b0;
    cyc(); otg_rst_n = 1'b1;
    push("srst_int", SEL_INT, 16'h0000);
    push("srst_wready", SEL_WREADY, 16'h0001);
    push("srst_rvalid", SEL_RVALID, 16'h0000);
    push("srst_rdata", SEL_RDATA, 16'h0000);
    bus_read(A_ADDR, 16'h0000, "srst_addr");
    bus_read(A_STAT, 16'h0000, "srst_status");
    bus_write(A_ADDR, 16'h0010);
    bus_read(A_DATA, 16'hA5A5, "srst_ram_kept");

    // Reset_n asserted during a write
    bus_write(A_ADDR, 16'h0010);
    cyc();
    otg_addr = A_DATA; tb_wdata = 16'h9999; tb_drv = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    reset_n = 1'b0;
    cyc();
    cyc();
    cs_n = 1'b1; wr_n = 1'b1; tb_drv = 1'b0;
    cyc();
    reset_n = 1'b1;
    bus_read(A_ADDR, 16'h0000, "hrst_addr");
    bus_write(A_ADDR, 16'h0010);
    bus_read(A_DATA, 16'hA5A5, "hrst_ram_kept");

    // Same-cycle host MAILBOX write and device ack
    cyc();
    otg_addr = A_MBX; tb_wdata = 16'h7777; tb_drv = 1'b1; cs_n = 1'b0; wr_n = 1'b0; dev_ack = 1'b1;
    cyc();
    cs_n = 1'b1; wr_n = 1'b1; tb_drv = 1'b0; dev_ack = 1'b0;
    push("coll_wr_rvalid", SEL_RVALID, 16'h0001);
    push("coll_wr_rdata", SEL_RDATA, 16'h7777);

    // Same-cycle host MAILBOX read and device write
    dev_write(16'h00AA);
    cyc();
    otg_addr = A_MBX; cs_n = 1'b0; rd_n = 1'b0; dev_wdata = 16'h0BBB; dev_we = 1'b1;
    cyc();
    dev_we = 1'b0;
    push("coll_rd_bus", SEL_BUS, 16'h00AA);
    push("coll_rd_int", SEL_INT, 16'h0000);
    cyc();
    cs_n = 1'b1; rd_n = 1'b1;
    bus_read(A_STAT, 16'h0100, "coll_status");

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
